// File: rtl/mix_columns_engine_pkg.sv
// Shared AES constants, FSM state type and the GF(2^8) xtime helper.
package aes_pkg;

   localparam logic [7:0]  AES_POLY = 8'h1b;
   localparam int unsigned AES_NB   = 4;
   localparam int unsigned COL_W    = 32;
   localparam int unsigned STATE_W  = AES_NB * COL_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Column 0 is the most significant word, byte 0 of a column its top byte.
   typedef logic [0:AES_NB-1][COL_W-1:0] state_t;

   // Multiply by 02 in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// Block-level handshake bus of the MixColumns engine.
interface mix_columns_engine_if;
   import aes_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic               inverse;
   logic [0:STATE_W-1] state_in;
   logic               out_valid;
   logic               out_ready;
   logic [0:STATE_W-1] state_out;
   logic               busy;

   modport master (
      output in_valid, inverse, state_in, out_ready,
      input  in_ready, out_valid, state_out, busy
   );

   modport slave (
      input  in_valid, inverse, state_in, out_ready,
      output in_ready, out_valid, state_out, busy
   );

endinterface

// File: rtl/mix_columns_engine_mix.sv
// Combinational (Inv)MixColumns of a single 32-bit column.
module gf_mix_column
   import aes_pkg::*;
(
   input  logic [COL_W-1:0] col_i,
   input  logic             inverse_i,
   output logic [COL_W-1:0] col_c_o
);

   logic [0:AES_NB-1][7:0] a;
   logic [0:AES_NB-1][7:0] r;
   logic [7:0] m2 [AES_NB];
   logic [7:0] m4 [AES_NB];
   logic [7:0] m8 [AES_NB];

   assign a       = col_i;
   assign col_c_o = r;

   // xtime chains per byte, then the circulant combination for each output byte.
   always_comb begin
      r = '0;
      for (int unsigned i = 0; i < AES_NB; i++) begin
         m2[i] = xtime(a[i]);
         m4[i] = xtime(m2[i]);
         m8[i] = xtime(m4[i]);
      end
      for (int unsigned i = 0; i < AES_NB; i++) begin
         if (inverse_i) begin
            r[i] = (m8[i] ^ m4[i] ^ m2[i])
                 ^ (m8[(i+1)%AES_NB] ^ m2[(i+1)%AES_NB] ^ a[(i+1)%AES_NB])
                 ^ (m8[(i+2)%AES_NB] ^ m4[(i+2)%AES_NB] ^ a[(i+2)%AES_NB])
                 ^ (m8[(i+3)%AES_NB] ^ a[(i+3)%AES_NB]);
         end else begin
            r[i] = m2[i]
                 ^ (m2[(i+1)%AES_NB] ^ a[(i+1)%AES_NB])
                 ^ a[(i+2)%AES_NB]
                 ^ a[(i+3)%AES_NB];
         end
      end
   end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative AES (Inv)MixColumns engine, COLS_PER_CYCLE columns per RUN cycle.
module mix_columns_engine
   import aes_pkg::*;
#(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   mix_columns_engine_if.slave bus
);

   localparam int unsigned CNT_W    = 2;
   localparam int unsigned CNT_LAST = AES_NB - COLS_PER_CYCLE;

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             inv_q, inv_d;
   state_t           work_q, work_d;
   logic             in_ready_q, out_valid_q, busy_q;

   logic [COL_W-1:0] col_sel [COLS_PER_CYCLE];
   logic [COL_W-1:0] col_mix [COLS_PER_CYCLE];

   // One mixer per column lane, fed from the columns selected by the counter.
   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
      assign col_sel[g] = work_q[CNT_W'(cnt_q + CNT_W'(g))];
      gf_mix_column u_mix (
         .col_i     (col_sel[g]),
         .inverse_i (inv_q),
         .col_c_o   (col_mix[g])
      );
   end

   // Next-state logic: capture, in-place column update, output handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inv_d   = inv_q;
      work_d  = work_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               work_d  = state_t'(bus.state_in);
               inv_d   = bus.inverse;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
               work_d[CNT_W'(cnt_q + CNT_W'(k))] = col_mix[k];
            end
            cnt_d = cnt_q + CNT_W'(COLS_PER_CYCLE);
            if (cnt_q == CNT_W'(CNT_LAST)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         inv_q       <= 1'b0;
         work_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         inv_q       <= inv_d;
         work_q      <= work_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == DONE);
         busy_q      <= (state_d != IDLE);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.state_out = work_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Scoreboard bench for mix_columns_engine at COLS_PER_CYCLE = 1, 2 and 4.
module tb_mix_columns_engine;

   localparam int NI = 3;
   localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] COL_IN   = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;
   localparam logic [127:0] COL_OUT  = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
   localparam logic [127:0] ONES     = {4{32'h01010101}};

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         in_valid  [NI];
   logic         inverse   [NI];
   logic         out_ready [NI];
   logic [127:0] state_in  [NI];
   logic         in_ready  [NI];
   logic         out_valid [NI];
   logic         busy      [NI];
   logic [127:0] state_out [NI];

   logic [127:0] exp_q [NI][$];
   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mix_columns_engine_if bus ();
      mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
      assign bus.in_valid  = in_valid[g];
      assign bus.inverse   = inverse[g];
      assign bus.state_in  = state_in[g];
      assign bus.out_ready = out_ready[g];
      assign in_ready[g]   = bus.in_ready;
      assign out_valid[g]  = bus.out_valid;
      assign busy[g]       = bus.busy;
      assign state_out[g]  = bus.state_out;
   end

   // Reference GF(2^8) multiply by shift-and-add.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p ^= aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
      logic [7:0]   cf [4];
      logic [7:0]   a  [4];
      logic [7:0]   acc;
      logic [127:0] r;
      r = '0;
      if (inv) begin
         cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
      end else begin
         cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
      end
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) a[j] = s[127-32*c-8*j -: 8];
         for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc ^= gmul(cf[k], a[(i+k)%4]);
            r[127-32*c-8*i -: 8] = acc;
         end
      end
      return r;
   endfunction

   // Scoreboard: every output handshake pops and compares one expected block.
   always @(negedge clk) begin
      logic [127:0] e;
      if (rst_n === 1'b1) begin
         for (int n = 0; n < NI; n++) begin
            if (out_valid[n] === 1'b1 && out_ready[n] === 1'b1) begin
               checks++;
               if (exp_q[n].size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected inst=%0d got=%h want=none", n, state_out[n]);
               end else begin
                  e = exp_q[n].pop_front();
                  if (state_out[n] !== e) begin
                     errors++;
                     $display("FAIL sb_data inst=%0d got=%h want=%h", n, state_out[n], e);
                  end
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Present one block, wait for acceptance, record its expected result.
   task automatic send(input int n, input logic [127:0] d, input logic inv, input logic [127:0] e);
      int t;
      t = 0;
      in_valid[n] = 1'b1; state_in[n] = d; inverse[n] = inv;
      @(negedge clk);
      while (in_ready[n] !== 1'b1 && t < 200) begin
         @(negedge clk); t++;
      end
      if (t >= 200) begin
         checks++; errors++;
         $display("FAIL send_timeout inst=%0d in_ready=%b want=1", n, in_ready[n]);
      end else begin
         exp_q[n].push_back(e);
      end
      @(posedge clk); #1;
      in_valid[n] = 1'b0; inverse[n] = ~inv; state_in[n] = ~d;
   endtask

   task automatic wait_drain(input int n);
      int t;
      t = 0;
      while ((exp_q[n].size() != 0 || in_ready[n] !== 1'b1) && t < 400) begin
         @(negedge clk); t++;
      end
      if (t >= 400) begin
         checks++; errors++;
         $display("FAIL drain_timeout inst=%0d pending=%0d want=0", n, exp_q[n].size());
      end
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int n = 0; n < NI; n++) begin
         checks++;
         if (out_valid[n] !== 1'b0 || busy[n] !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs inst=%0d out_valid=%b busy=%b want=0/0", n, out_valid[n], busy[n]);
         end
      end
      rst_n = 1'b1;
      tick();
      for (int n = 0; n < NI; n++) begin
         checks++;
         if (in_ready[n] !== 1'b1 || out_valid[n] !== 1'b0 || busy[n] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release inst=%0d in_ready=%b out_valid=%b busy=%b want=1/0/0",
                     n, in_ready[n], out_valid[n], busy[n]);
         end
      end
   endtask

   task automatic test_vectors();
      for (int n = 0; n < NI; n++) begin
         send(n, FIPS_IN, 1'b0, FIPS_OUT);  wait_drain(n);
         send(n, FIPS_OUT, 1'b1, FIPS_IN);  wait_drain(n);
         send(n, COL_IN, 1'b0, COL_OUT);    wait_drain(n);
      end
   endtask

   task automatic test_latency();
      int cyc;
      for (int n = 0; n < NI; n++) begin
         send(n, FIPS_IN, 1'b0, FIPS_OUT);
         checks++;
         if (in_ready[n] !== 1'b0 || busy[n] !== 1'b1) begin
            errors++;
            $display("FAIL run_status inst=%0d in_ready=%b busy=%b want=0/1", n, in_ready[n], busy[n]);
         end
         cyc = 0;
         while (out_valid[n] !== 1'b1 && cyc < 20) begin
            tick(); cyc++;
         end
         checks++;
         if (cyc != (4 >> n)) begin
            errors++;
            $display("FAIL latency inst=%0d cycles=%0d want=%0d", n, cyc, 4 >> n);
         end
         wait_drain(n);
      end
   endtask

   task automatic test_backpressure();
      int t;
      out_ready[0] = 1'b0;
      send(0, FIPS_IN, 1'b0, FIPS_OUT);
      t = 0;
      while (out_valid[0] !== 1'b1 && t < 20) begin
         tick(); t++;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid[0] !== 1'b1 || state_out[0] !== FIPS_OUT || in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL backpressure cyc=%0d out_valid=%b in_ready=%b busy=%b got=%h want=1/0/1 %h",
                     i, out_valid[0], in_ready[0], busy[0], state_out[0], FIPS_OUT);
         end
      end
      tick();
      out_ready[0] = 1'b1;
      tick();
      checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL bp_release in_ready=%b out_valid=%b busy=%b want=1/0/0", in_ready[0], out_valid[0], busy[0]);
      end
      wait_drain(0);
   endtask

   task automatic test_reset_abort();
      in_valid[0] = 1'b1; inverse[0] = 1'b0;
      state_in[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      tick(); tick();
      rst_n = 1'b0;
      state_in[0] = ONES;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset out_valid=%b busy=%b want=0/0", out_valid[0], busy[0]);
         end
      end
      exp_q[0].push_back(ONES);
      rst_n = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      checks++;
      if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL first_edge_accept busy=%b out_valid=%b want=1/0", busy[0], out_valid[0]);
      end
      wait_drain(0);
   endtask

   task automatic test_random();
      bit done;
      done = 1'b0;
      fork
         begin
            logic [127:0] x, y;
            int n;
            for (int i = 0; i < 500; i++) begin
               n = i % NI;
               x = {$urandom(), $urandom(), $urandom(), $urandom()};
               y = model(x, 1'b0);
               repeat ($urandom_range(0, 3)) tick();
               send(n, x, 1'b0, y);
               repeat ($urandom_range(0, 3)) tick();
               send(n, y, 1'b1, x);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               tick();
               for (int n = 0; n < NI; n++) out_ready[n] = ($urandom_range(0, 2) != 0);
            end
         end
      join
      for (int n = 0; n < NI; n++) out_ready[n] = 1'b1;
      for (int n = 0; n < NI; n++) wait_drain(n);
   endtask

   initial begin
      for (int n = 0; n < NI; n++) begin
         in_valid[n] = 1'b0; inverse[n] = 1'b0; out_ready[n] = 1'b1; state_in[n] = '0;
      end
      test_reset();
      test_vectors();
      test_latency();
      test_backpressure();
      test_reset_abort();
      test_random();
      for (int n = 0; n < NI; n++) begin
         checks++;
         if (exp_q[n].size() != 0) begin
            errors++;
            $display("FAIL final_pending inst=%0d pending=%0d want=0", n, exp_q[n].size());
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
